// File: rtl/contador_bcd_display_n_if.sv
// Control/status bundle of the N-digit BCD counter with multiplexed 7-segment driver.
// The master side drives the count controls; the slave side (the counter) returns
// the BCD value, the display drive and the status pulses.
interface contador_bcd_display_n_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    up;
  logic                    clear;
  logic                    blank_lz;
  logic [4*NUM_DIGITS-1:0] count;
  logic [7:0]              segmentos;
  logic [NUM_DIGITS-1:0]   sel_seg;
  logic                    tick;
  logic                    wrap;

  modport master (
    output en, up, clear, blank_lz,
    input  count, segmentos, sel_seg, tick, wrap
  );

  modport slave (
    input  en, up, clear, blank_lz,
    output count, segmentos, sel_seg, tick, wrap
  );
endinterface

// File: rtl/contador_bcd_display_n.sv
// N-digit BCD up/down counter with a time-multiplexed 7-segment driver.
// A prescaler turns the enabled clock into count steps; an independent, free-running
// scan counter walks the digit select. Select and segment lines are registered
// together from the post-edge index and count, so they can never disagree.
module contador_bcd_display_n #(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 10_000_000,
  parameter int SCAN_DIV       = 10_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  contador_bcd_display_n_if.slave bus
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0]         PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0]         SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0]         ALL_NINES = {NUM_DIGITS{4'h9}};
  localparam logic [CW-1:0]         ALL_ZERO  = {CW{1'b0}};
  localparam logic [7:0]            SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]            SEG_ZERO  = SEG_ACTIVE_LOW ? 8'hC0 : 8'h3F;
  localparam logic [NUM_DIGITS-1:0] SEL_ONE   = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] SEL_RST   = SEL_ACTIVE_LOW ? ~SEL_ONE : SEL_ONE;

  // Active-high a-g glyph for a BCD digit; codes above 9 never occur and stay dark.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // Full 8-bit segment drive with dp forced off and the pad polarity applied.
  function automatic logic [7:0] seg_drive(input logic [6:0] g);
    return {1'b0, g} ^ {8{SEG_ACTIVE_LOW}};
  endfunction

  // One BCD step with ripple carry (up) or borrow (down) across all digits.
  function automatic logic [CW-1:0] bcd_step(input logic [CW-1:0] v, input logic dir_up);
    logic [CW-1:0] r;
    logic [3:0]    d;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (!c) begin
        r[4*i +: 4] = d;
      end else if (dir_up) begin
        if (d == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          c           = 1'b1;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          c           = 1'b0;
        end
      end else begin
        if (d == 4'd0) begin
          r[4*i +: 4] = 4'd9;
          c           = 1'b1;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Picks the nibble of the digit currently being scanned.
  function automatic logic [3:0] digit_at(input logic [CW-1:0] v, input logic [IW-1:0] idx);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == int'(idx)) begin
        d = v[4*i +: 4];
      end else begin
        d = d;
      end
    end
    return d;
  endfunction

  // A digit is a leading zero when it is not digit 0 and it and every higher digit are 0.
  function automatic logic is_leading_zero(input logic [CW-1:0] v, input logic [IW-1:0] idx);
    logic nz;
    nz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx)) && (v[4*i +: 4] != 4'd0)) begin
        nz = 1'b1;
      end else begin
        nz = nz;
      end
    end
    return (idx != IW'(0)) && !nz;
  endfunction

  logic [CW-1:0]         count_r;
  logic [PW-1:0]         presc_r;
  logic                  tick_r;
  logic                  wrap_r;
  logic [SW-1:0]         scan_r;
  logic [IW-1:0]         idx_r;
  logic [NUM_DIGITS-1:0] sel_r;
  logic [7:0]            seg_r;

  logic                  step_s;
  logic [CW-1:0]         count_nxt_s;
  logic [PW-1:0]         presc_nxt_s;
  logic                  tick_nxt_s;
  logic                  wrap_nxt_s;
  logic [SW-1:0]         scan_nxt_s;
  logic [IW-1:0]         idx_nxt_s;
  logic [NUM_DIGITS-1:0] sel_nxt_s;
  logic [7:0]            seg_nxt_s;
  logic [3:0]            digit_s;
  logic                  blank_s;

  // Prescaler and counter next state; clear wins over a coincident step.
  always_comb begin
    step_s      = bus.en && (presc_r == PRESC_MAX);
    count_nxt_s = count_r;
    presc_nxt_s = presc_r;
    tick_nxt_s  = 1'b0;
    wrap_nxt_s  = 1'b0;
    if (bus.clear) begin
      count_nxt_s = ALL_ZERO;
      presc_nxt_s = {PW{1'b0}};
    end else if (step_s) begin
      count_nxt_s = bcd_step(count_r, bus.up);
      presc_nxt_s = {PW{1'b0}};
      tick_nxt_s  = 1'b1;
      wrap_nxt_s  = bus.up ? (count_r == ALL_NINES) : (count_r == ALL_ZERO);
    end else if (bus.en) begin
      presc_nxt_s = presc_r + PW'(1);
    end else begin
      presc_nxt_s = presc_r;
    end
  end

  // Free-running scan timer and digit index, unaffected by en and clear.
  always_comb begin
    scan_nxt_s = scan_r;
    idx_nxt_s  = idx_r;
    if (scan_r == SCAN_MAX) begin
      scan_nxt_s = {SW{1'b0}};
      if (idx_r == IDX_MAX) begin
        idx_nxt_s = {IW{1'b0}};
      end else begin
        idx_nxt_s = idx_r + IW'(1);
      end
    end else begin
      scan_nxt_s = scan_r + SW'(1);
      idx_nxt_s  = idx_r;
    end
  end

  // Display drive computed from the index and count that this edge will load.
  always_comb begin
    sel_nxt_s = SEL_ONE << idx_nxt_s;
    if (SEL_ACTIVE_LOW) begin
      sel_nxt_s = ~sel_nxt_s;
    end else begin
      sel_nxt_s = sel_nxt_s;
    end
    digit_s = digit_at(count_nxt_s, idx_nxt_s);
    blank_s = bus.blank_lz && is_leading_zero(count_nxt_s, idx_nxt_s);
    if (blank_s) begin
      seg_nxt_s = SEG_OFF;
    end else begin
      seg_nxt_s = seg_drive(glyph(digit_s));
    end
  end

  // State and output registers with immediate asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= ALL_ZERO;
      presc_r <= {PW{1'b0}};
      tick_r  <= 1'b0;
      wrap_r  <= 1'b0;
      scan_r  <= {SW{1'b0}};
      idx_r   <= {IW{1'b0}};
      sel_r   <= SEL_RST;
      seg_r   <= SEG_ZERO;
    end else begin
      count_r <= count_nxt_s;
      presc_r <= presc_nxt_s;
      tick_r  <= tick_nxt_s;
      wrap_r  <= wrap_nxt_s;
      scan_r  <= scan_nxt_s;
      idx_r   <= idx_nxt_s;
      sel_r   <= sel_nxt_s;
      seg_r   <= seg_nxt_s;
    end
  end

  assign bus.count     = count_r;
  assign bus.tick      = tick_r;
  assign bus.wrap      = wrap_r;
  assign bus.sel_seg   = sel_r;
  assign bus.segmentos = seg_r;

endmodule

// File: tb/tb_contador_bcd_display_n.sv
// Self-checking bench for contador_bcd_display_n (2 digits, TICK_DIV=4, SCAN_DIV=2,
// active-high polarities). The reference model keeps the count as a plain integer 0..99.
module tb_contador_bcd_display_n;

  localparam int ND   = 2;
  localparam int TDIV = 4;
  localparam int SDIV = 2;
  localparam int MAXV = 100;

  logic clk;
  logic rst;

  contador_bcd_display_n_if #(.NUM_DIGITS(ND)) bus_if ();

  contador_bcd_display_n #(
    .NUM_DIGITS    (ND),
    .TICK_DIV      (TDIV),
    .SCAN_DIV      (SDIV),
    .SEG_ACTIVE_LOW(1'b0),
    .SEL_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_val, m_presc, m_scan, m_idx;
  bit m_tick, m_wrap, m_blz;
  int wraps_seen;

  logic [7:0] glyph_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_val   = 0;
    m_presc = 0;
    m_scan  = 0;
    m_idx   = 0;
    m_tick  = 1'b0;
    m_wrap  = 1'b0;
    m_blz   = 1'b0;
  endtask

  task automatic model_edge(input bit e, input bit u, input bit c, input bit b);
    m_blz = b;
    if (c) begin
      m_val   = 0;
      m_presc = 0;
      m_tick  = 1'b0;
      m_wrap  = 1'b0;
    end else if (e && m_presc == TDIV - 1) begin
      m_wrap  = u ? (m_val == MAXV - 1) : (m_val == 0);
      m_val   = u ? (m_val + 1) % MAXV : (m_val + MAXV - 1) % MAXV;
      m_presc = 0;
      m_tick  = 1'b1;
    end else begin
      if (e) m_presc++;
      m_tick = 1'b0;
      m_wrap = 1'b0;
    end
    if (m_scan == SDIV - 1) begin
      m_scan = 0;
      m_idx  = (m_idx + 1) % ND;
    end else begin
      m_scan++;
    end
  endtask

  task automatic check_all();
    int         pw;
    int         dig;
    bit         blank;
    logic [7:0] exp_count;
    logic [7:0] exp_seg;
    exp_count = 8'(((m_val / 10) % 10) * 16 + (m_val % 10));
    pw        = (m_idx == 0) ? 1 : 10;
    dig       = (m_val / pw) % 10;
    blank     = m_blz && (m_idx > 0) && (m_val < pw);
    exp_seg   = blank ? 8'h00 : glyph_tab[dig];
    chk_eq("count",     32'(bus_if.count),     32'(exp_count));
    chk_eq("tick",      32'(bus_if.tick),      32'(m_tick));
    chk_eq("wrap",      32'(bus_if.wrap),      32'(m_wrap));
    chk_eq("sel_seg",   32'(bus_if.sel_seg),   32'(1 << m_idx));
    chk_eq("segmentos", 32'(bus_if.segmentos), 32'(exp_seg));
  endtask

  task automatic cyc(input bit e, input bit u, input bit c, input bit b);
    bus_if.en       = e;
    bus_if.up       = u;
    bus_if.clear    = c;
    bus_if.blank_lz = b;
    @(posedge clk);
    model_edge(e, u, c, b);
    #1;
    check_all();
    if (bus_if.wrap === 1'b1) wraps_seen++;
  endtask

  task automatic run_to(input int target, input bit u, input bit b);
    int guard;
    guard = 0;
    while (m_val != target && guard < 2000) begin
      cyc(1'b1, u, 1'b0, b);
      guard++;
    end
    chk_eq("run_to_bound", 32'(m_val), 32'(target));
  endtask

  initial begin
    rst             = 1'b1;
    bus_if.en       = 1'b0;
    bus_if.up       = 1'b1;
    bus_if.clear    = 1'b0;
    bus_if.blank_lz = 1'b0;
    wraps_seen      = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // 100 full up steps: passes 09->10 and rolls 99->00 exactly once
    for (int i = 0; i < 100 * TDIV; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk_eq("wrap_once", 32'(wraps_seen), 32'd1);

    // asynchronous reset in the middle of a cycle at count 37
    run_to(37, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk_eq("rst_async_count", 32'(bus_if.count), 32'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();

    // clear landing on a step edge at 42
    run_to(42, 1'b1, 1'b0);
    while (m_presc != TDIV - 1) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= TDIV; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk_eq("step_after_clear", 32'(bus_if.tick), 32'(k == TDIV));
    end

    // down from 00: wrap to 99 then 98
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    wraps_seen = 0;
    for (int i = 0; i < 2 * TDIV; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk_eq("down_val", 32'(bus_if.count), 32'h98);
    chk_eq("down_wrap_once", 32'(wraps_seen), 32'd1);

    // enable dropped mid-period for 20 cycles
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < TDIV; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);

    // leading-zero blanking at 05
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    run_to(5, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(bit'($urandom_range(0, 9) != 0), bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 63) == 0), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
